// File: rtl/calc_pkg.sv
// calc_pkg: shared state encodings, digit slots, anode patterns and digit helpers
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        WAIT    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } digits_t;

    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [3:0] AN_ONES = 4'b1110;
    localparam logic [3:0] AN_TENS = 4'b1101;
    localparam logic [3:0] AN_HUND = 4'b1011;

    function automatic logic [1:0] next_dig(input logic [1:0] d);
        return d == DIG_HUND ? DIG_ONES : d + 2'd1;
    endfunction

    function automatic digits_t sw_digits(input logic [3:0] v);
        return '{h: 4'd0, t: {3'd0, v >= 4'd10}, o: v >= 4'd10 ? v - 4'd10 : v};
    endfunction

endpackage

// File: rtl/calc_sequencer_scan_timer.sv
// scan_timer: divides clk into digit slots and steps the ones/tens/hundreds index
module scan_timer
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] index,
    output logic       tick
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(SCAN_DIV - 1);

    // slot counter wraps every SCAN_DIV cycles and advances the digit index on wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            index <= DIG_ONES;
        end else begin
            cnt   <= tick ? '0 : cnt + 1'b1;
            index <= tick ? next_dig(index) : index;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: operand entry FSM, result capture and 7-segment scan for the 4x4 calculator
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int MUL_LAT  = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn_enter,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic [3:0] display,
    output logic [3:0] an,
    output logic       result_valid,
    output logic [1:0] state
);

    localparam int WW = $clog2(MUL_LAT) + 1;

    state_t     st, st_nxt;
    logic       btn_q, press;
    logic       ld_a, ld_b, cap, clr;
    logic [WW-1:0] wcnt;
    digits_t    r, shown;
    logic [1:0] index, slot;
    logic       tick, blank_h, blank_t;
    logic [3:0] an_nxt, disp_nxt;

    scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst   (rst),
        .index (index),
        .tick  (tick)
    );

    assign press = btn_enter & ~btn_q;
    assign state = st;

    // next state and datapath load strobes; presses are only honoured outside WAIT
    always_comb begin
        ld_a   = press && st == ENTER_A;
        ld_b   = press && st == ENTER_B;
        cap    = st == WAIT && wcnt == '0;
        clr    = press && st == SHOW;
        st_nxt = ld_a ? ENTER_B : ld_b ? WAIT : cap ? SHOW : clr ? ENTER_A : st;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) st <= ENTER_A;
        else st <= st_nxt;
    end

    // edge detect, operand latches, multiplier settle countdown and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q        <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            wcnt         <= '0;
            r            <= '0;
            result_valid <= 1'b0;
        end else begin
            btn_q <= btn_enter;
            if (ld_a) op_a <= sw;
            if (ld_b) op_b <= sw;
            if (ld_b) wcnt <= WW'(MUL_LAT - 1);
            else if (st == WAIT && !cap) wcnt <= wcnt - 1'b1;
            if (cap) r <= '{h: hundreds, t: tens, o: ones};
            if (cap) result_valid <= 1'b1;
            else if (clr) result_valid <= 1'b0;
        end
    end

    // digit source and anode pattern for the slot that becomes active on this edge
    always_comb begin
        shown    = (st == WAIT || st == SHOW) ? r : sw_digits(sw);
        slot     = tick ? next_dig(index) : index;
        blank_h  = BLANK_LZ != 0 && shown.h == 4'd0;
        blank_t  = blank_h && shown.t == 4'd0;
        an_nxt   = slot == DIG_ONES ? AN_ONES :
                   slot == DIG_TENS ? (blank_t ? AN_OFF : AN_TENS) :
                   (blank_h ? AN_OFF : AN_HUND);
        disp_nxt = slot == DIG_ONES ? shown.o : slot == DIG_TENS ? shown.t : shown.h;
    end

    // registered segment outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an      <= AN_ONES;
            display <= '0;
        end else begin
            an      <= an_nxt;
            display <= disp_nxt;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: random operand pairs checked by scoreboard and a per-cycle behavioural model
module tb_calc_sequencer;

    localparam int SD = 4;
    localparam int ML = 2;

    logic       clk = 1'b0;
    logic       rst, btn_enter;
    logic [3:0] sw, hundreds, tens, ones;
    logic [3:0] op_a, op_b, display, an, op_a1, op_b1, display1, an1;
    logic       result_valid, result_valid1;
    logic [1:0] state, state1;

    int total = 0;
    int bad = 0;

    calc_sequencer #(.SCAN_DIV(SD), .MUL_LAT(ML), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter),
        .hundreds(hundreds), .tens(tens), .ones(ones),
        .op_a(op_a), .op_b(op_b), .display(display), .an(an),
        .result_valid(result_valid), .state(state)
    );

    calc_sequencer #(.SCAN_DIV(SD), .MUL_LAT(ML), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter),
        .hundreds(hundreds), .tens(tens), .ones(ones),
        .op_a(op_a1), .op_b(op_b1), .display(display1), .an(an1),
        .result_valid(result_valid1), .state(state1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: mode 0=entering A, 1=entering B, 2=settling, 3=showing
    int         m_mode, m_wl, m_k;
    logic [3:0] m_a, m_b, m_h, m_t, m_o, e_an, e_an0, e_disp;
    logic       m_v, m_prev, armed = 1'b0;
    logic       m_press;
    logic [3:0] s_h, s_t, s_o;
    int         slot;

    assign m_press = btn_enter && !m_prev;
    assign s_h  = m_mode >= 2 ? m_h : 4'd0;
    assign s_t  = m_mode >= 2 ? m_t : (sw >= 4'd10 ? 4'd1 : 4'd0);
    assign s_o  = m_mode >= 2 ? m_o : 4'(sw % 10);
    assign slot = ((m_k + 1) / SD) % 3;

    function automatic logic [3:0] exp_an(input int sl, input logic [3:0] h, input logic [3:0] t, input bit blank);
        if (sl == 0) return 4'b1110;
        if (sl == 1) return (blank && h == 0 && t == 0) ? 4'b1111 : 4'b1101;
        return (blank && h == 0) ? 4'b1111 : 4'b1011;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            armed <= 1'b1;
            m_mode <= 0; m_wl <= 0; m_k <= 0; m_prev <= 1'b0; m_v <= 1'b0;
            m_a <= 0; m_b <= 0; m_h <= 0; m_t <= 0; m_o <= 0;
            e_an <= 4'b1110; e_an0 <= 4'b1110; e_disp <= 0;
        end else begin
            m_prev <= btn_enter;
            m_k    <= m_k + 1;
            e_an   <= exp_an(slot, s_h, s_t, 1'b1);
            e_an0  <= exp_an(slot, s_h, s_t, 1'b0);
            e_disp <= slot == 0 ? s_o : slot == 1 ? s_t : s_h;
            if (m_mode == 0 && m_press) begin
                m_a <= sw; m_mode <= 1;
            end else if (m_mode == 1 && m_press) begin
                m_b <= sw; m_wl <= ML; m_mode <= 2;
            end else if (m_mode == 2) begin
                if (m_wl == 1) begin
                    m_h <= hundreds; m_t <= tens; m_o <= ones; m_v <= 1'b1; m_mode <= 3;
                end else m_wl <= m_wl - 1;
            end else if (m_mode == 3 && m_press) begin
                m_v <= 1'b0; m_mode <= 0;
            end
        end
    end

    logic [7:0] sbq[$];
    logic       rv_q = 1'b0;

    // per-cycle model comparison plus scoreboard pop on every new result
    always @(negedge clk) begin
        if (armed) begin
            chk("state", 32'(state), 32'(m_mode));
            chk("op_a", 32'(op_a), 32'(m_a));
            chk("op_b", 32'(op_b), 32'(m_b));
            chk("result_valid", 32'(result_valid), 32'(m_v));
            chk("an", 32'(an), 32'(e_an));
            chk("display", 32'(display), 32'(e_disp));
            chk("nb_state", 32'(state1), 32'(m_mode));
            chk("nb_op_a", 32'(op_a1), 32'(m_a));
            chk("nb_op_b", 32'(op_b1), 32'(m_b));
            chk("nb_result_valid", 32'(result_valid1), 32'(m_v));
            chk("nb_an", 32'(an1), 32'(e_an0));
            chk("nb_display", 32'(display1), 32'(e_disp));
            if (result_valid && !rv_q) begin
                if (sbq.size() == 0) chk("sb_unexpected_result", 32'(result_valid), 32'(0));
                else begin
                    chk("sb_op_a", 32'(op_a), 32'(sbq[0][7:4]));
                    chk("sb_op_b", 32'(op_b), 32'(sbq[0][3:0]));
                    chk("sb_state", 32'(state), 32'(3));
                    sbq.delete(0);
                end
            end
        end
        rv_q <= result_valid;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press();
        btn_enter = 1'b1;
        cyc(1);
        btn_enter = 1'b0;
        cyc(1);
    endtask

    task automatic set_dec(input int a, input int b);
        int p;
        p = a * b;
        hundreds = 4'(p / 100);
        tens     = 4'(p / 10 % 10);
        ones     = 4'(p % 10);
    endtask

    task automatic op(input int a, input int b, input bit wpress);
        sw = 4'(a);
        cyc(1 + $urandom_range(0, 3));
        press();
        sw = 4'(b);
        set_dec(a, b);
        sbq.push_back({4'(a), 4'(b)});
        press();
        if (wpress) begin
            btn_enter = 1'b1;
            cyc(2);
            btn_enter = 1'b0;
        end
        cyc(13 + $urandom_range(0, 6));
        press();
        sw = 4'($urandom_range(0, 15));
        cyc(2 + $urandom_range(0, 6));
    endtask

    initial begin
        rst = 1'b1; btn_enter = 1'b0; sw = 4'd0;
        hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
        cyc(3);
        rst = 1'b0;
        chk("rst_an", 32'(an), 32'(4'b1110));
        chk("rst_state", 32'(state), 32'(0));
        cyc(14);
        op(7, 9, 1'b0);
        op(15, 15, 1'b1);
        sw = 4'd5;
        btn_enter = 1'b1;
        cyc(20);
        btn_enter = 1'b0;
        cyc(1);
        chk("held_state", 32'(state), 32'(1));
        chk("held_op_a", 32'(op_a), 32'(5));
        sw = 4'd3;
        set_dec(5, 3);
        sbq.push_back({4'd5, 4'd3});
        press();
        cyc(14);
        press();
        sw = 4'd12;
        cyc(14);
        sw = 4'd3;
        press();
        sw = 4'd5;
        set_dec(3, 5);
        press();
        rst = 1'b1;
        sbq.delete();
        cyc(1);
        rst = 1'b0;
        chk("wait_rst_state", 32'(state), 32'(0));
        chk("wait_rst_op_a", 32'(op_a), 32'(0));
        chk("wait_rst_op_b", 32'(op_b), 32'(0));
        chk("wait_rst_an", 32'(an), 32'(4'b1110));
        cyc(5);
        op(2, 2, 1'b0);
        for (int i = 0; i < 40; i++)
            op($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        cyc(2);
        chk("sb_drained", 32'(sbq.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
